ps2_scancode_rx: RTL
====================

# ps2_scancode_rx

PS/2 keyboard front end. It synchronises and deglitches the raw PS/2 clock and data lines, then deserialises 11-bit device-to-host frames with parity and stop checks. It folds E0/F0 prefix bytes into a single tagged scancode event. The event is delivered as a one-cycle `valid` pulse to the keyboard key-decoding stage downstream.

## Interface
Parameters:
- `FILTER_LEN`, default 8: consecutive equal synchronised samples needed before the filtered PS/2 clock changes level.
- `TIMEOUT_CYCLES`, default 65000 (1 ms at 65 MHz): maximum `clk` cycles allowed between falling edges inside a frame.

Ports:
- `clk`  in  1  system clock; the single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous to `clk`.
- `scancode`  out  8  final (non-prefix) byte of the event.
- `is_ext`  out  1  event was preceded by E0.
- `is_break`  out  1  event was preceded by F0 (key release).
- `keycode`  out  16  upper byte is F0 if `is_break`, else E0 if `is_ext`, else 00; lower byte is `scancode`.
- `valid`  out  1  one-cycle strobe; `scancode`, `is_ext`, `is_break` and `keycode` are meaningful while it is high.
- `err`  out  1  one-cycle strobe on a parity, stop-bit or timeout failure.

## Operation
- **Synchroniser.** Each raw pin passes through a 2-FF synchroniser with reset value 1.
- **Glitch filter.** The filtered clock starts at 1 after reset. It changes level only after `FILTER_LEN` consecutive synchronised samples disagree with its current value.
- **Falling-edge detect.** A one-cycle `fall` pulse fires when the filtered clock goes 1→0. Synchronised data is sampled on that same cycle.
- **Frame FSM, states IDLE, DATA, PARITY, STOP.**
  - IDLE: on `fall` with data=0, go to DATA with bit count 0. On `fall` with data=1, stay in IDLE, no `err`.
  - DATA: on each `fall`, shift the bit in LSB first. After the 8th bit go to PARITY.
  - PARITY: capture the bit and go to STOP. Check odd parity: XOR of the 8 data bits and the parity bit must equal 1.
  - STOP: on `fall`, the stop bit must be 1 and parity must be good. If both hold, the byte is accepted; otherwise pulse `err`. Return to IDLE either way.
- **Timeout.** The counter clears on every `fall` and in IDLE. If it reaches `TIMEOUT_CYCLES` outside IDLE: pulse `err`, go to IDLE, discard any partial byte.
- **Prefix handling on an accepted byte.**
  - E0: set the pending-ext flag, no `valid`.
  - F0: set the pending-break flag, no `valid`.
  - Any other byte: pulse `valid` with the pending flags, then clear both flags.
  - `err` also clears both pending flags.
- **Output holding.** Data outputs hold their last value between `valid` pulses.
- **Prefix order.** E0 followed by F0 gives `is_ext=1`, `is_break=1`, and `keycode` upper byte F0. F0 followed by E0 sets the same flags.
- **Reset.** `rst` asserted at any time, including mid-frame, forces:
  - FSM to IDLE; counters, shift register and flags cleared.
  - All outputs to 0.
  - Synchroniser and filtered clock to 1.

## Timing
- Pipeline from a raw `ps2_clk` fall to `fall`: 2 synchroniser cycles, then `FILTER_LEN` filter cycles, then 1 edge-detect cycle.
- `valid`/`err` are registered and rise exactly 1 cycle after the `fall` of the stop bit.
- Total latency from the raw stop-bit clock fall to `valid` is exactly `FILTER_LEN + 4` cycles, for a glitch-free input.
- `valid` and `err` are each exactly one cycle wide and are never high together.
- Glitches shorter than `FILTER_LEN` cycles on `ps2_clk` produce no `fall`.
- There is no backpressure. The downstream stage must accept every `valid`; the minimum spacing between strobes is one PS/2 frame (≥ 11 × 60 µs).

## Structure
- Package `ps2_pkg` holds:
  - the FSM state enum;
  - constants `PS2_EXT` = 8'hE0 and `PS2_BRK` = 8'hF0;
  - the frame bit count, 11.
- Sub-module `ps2_line_filter` (parameter `FILTER_LEN`) contains the 2-FF synchroniser, glitch filter and falling-edge detector. It outputs `fall` and the synchronised data bit.
- The top level contains the frame FSM, timeout counter, prefix folding and output registers.

## Test plan
- Frame byte 1C with parity bit 0 and stop bit 1, 12 kHz bus clock → one `valid` with `scancode`=1C, `is_ext`=0, `is_break`=0, `keycode`=001C; no `err`.
- Frames F0 then 1C → only one `valid`, with `is_break`=1 and `keycode`=F01C. A following frame 1C → `valid` with `keycode`=001C (flags cleared).
- Frames E0, F0, 75 → one `valid` with `is_ext`=1, `is_break`=1, `keycode`=F075.
- Frame 1C sent with a wrong parity bit → `err` one cycle, no `valid`. Then F0 with a bad stop bit followed by 1C → `err`, then `keycode`=001C (pending flag cleared).
- Send 4 bits, then hold `ps2_clk` high → `err` exactly `TIMEOUT_CYCLES` after the last `fall`. A following good frame 29 → `valid` with 0029.
- 3-cycle glitches on `ps2_clk` during an idle bus → no `fall`, no output activity.
- `rst` pulsed mid-frame → all outputs 0 immediately. A full frame 29 afterwards is received correctly.

Source files
------------

// File: rtl/ps2_scancode_rx_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 scancode receiver.
//   ps2_state_e  - frame FSM state encoding
//   PS2_EXT      - extended-key prefix byte (E0)
//   PS2_BRK      - key-release prefix byte (F0)
//   PS2_FRAME_BITS / PS2_DATA_BITS - frame geometry (start + 8 data + parity + stop)
//   keycode_hi() - upper byte of the 16-bit keycode from the prefix flags
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam logic [7:0] PS2_BRK        = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;
    localparam int         PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

    // Break wins over extended so E0 F0 xx and F0 E0 xx both report F0.
    function automatic logic [7:0] keycode_hi(input logic brk, input logic ext);
        if (brk)
            return PS2_BRK;
        else if (ext)
            return PS2_EXT;
        else
            return 8'h00;
    endfunction

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// ps2_scancode_rx_if: decoded key event bus from the PS/2 receiver to the
// key-decoding stage.
//   scancode - final (non-prefix) byte of the event
//   is_ext   - event was preceded by E0
//   is_break - event was preceded by F0
//   keycode  - {F0/E0/00, scancode}
//   valid    - one-cycle strobe qualifying the fields above
//   err      - one-cycle strobe on parity, stop-bit or timeout failure
// master: receiver side (drives), slave: consumer side.
interface ps2_scancode_rx_if;
    logic [7:0]  scancode;
    logic        is_ext;
    logic        is_break;
    logic [15:0] keycode;
    logic        valid;
    logic        err;

    modport master (
        output scancode, is_ext, is_break, keycode, valid, err
    );

    modport slave (
        input scancode, is_ext, is_break, keycode, valid, err
    );
endinterface

// File: rtl/ps2_scancode_rx_line_filter.sv
// ps2_line_filter: conditions the raw PS/2 pins for the frame FSM.
//   clk, rst  - system clock, async active-high reset
//   ps2_clk   - raw PS/2 clock pin (asynchronous)
//   ps2_data  - raw PS/2 data pin (asynchronous)
//   fall      - one-cycle pulse on a 1->0 transition of the filtered clock
//   data      - synchronised data bit, valid to sample while fall is high
// Both pins go through a 2-FF synchroniser; the clock is then deglitched by
// requiring FILTER_LEN consecutive disagreeing samples before it changes level.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic data
);

    localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

    logic          clk_s1_q, clk_s2_q;
    logic          dat_s1_q, dat_s2_q;
    logic          filt_q, filt_d;
    logic          filt_dly_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fall_q, fall_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (clk_s2_q != filt_q) begin
            // The FILTER_LEN-th disagreeing sample flips the level.
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = ~filt_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        // Edge detect uses a registered copy so fall trails the filter by a cycle.
        fall_d = filt_dly_q & ~filt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            filt_q     <= 1'b1;
            filt_dly_q <= 1'b1;
            cnt_q      <= '0;
            fall_q     <= 1'b0;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
            filt_q     <= filt_d;
            filt_dly_q <= filt_q;
            cnt_q      <= cnt_d;
            fall_q     <= fall_d;
        end
    end

    // PS/2 data is stable for half a bus period around the clock fall, far
    // longer than the filter delay, so the unfiltered synchronised bit is safe.
    assign fall = fall_q;
    assign data = dat_s2_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 keyboard front end.
//   clk, rst  - system clock, async active-high reset
//   ps2_clk   - raw PS/2 clock pin
//   ps2_data  - raw PS/2 data pin
//   evt       - key event bus (scancode, is_ext, is_break, keycode, valid, err)
// Deserialises 11-bit device-to-host frames, checks odd parity and the stop
// bit, enforces an inter-edge timeout, and folds E0/F0 prefixes into a single
// tagged event strobed on evt.valid.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    ps2_scancode_rx_if.master evt
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // tmo_q is 0 on the cycle after fall; err adds a register stage, so
    // expiring at TIMEOUT_CYCLES-2 makes err rise TIMEOUT_CYCLES after fall.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 2);

    logic fall;
    logic sdata;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filt (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .fall     (fall),
        .data     (sdata)
    );

    ps2_state_e    state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_ok_q, par_ok_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ext_pend_q, ext_pend_d;
    logic          brk_pend_q, brk_pend_d;
    logic [7:0]    scancode_q, scancode_d;
    logic          is_ext_q, is_ext_d;
    logic          is_break_q, is_break_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        par_ok_d   = par_ok_q;
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        scancode_d = scancode_q;
        is_ext_d   = is_ext_q;
        is_break_d = is_break_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;

        if (state_q == ST_IDLE || fall)
            tmo_d = '0;
        else
            tmo_d = tmo_q + TW'(1);

        unique case (state_q)
            ST_IDLE: begin
                // A fall with data high is line noise, not a start bit.
                if (fall && !sdata) begin
                    state_d  = ST_DATA;
                    bitcnt_d = '0;
                    shift_d  = '0;
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shift_d  = {sdata, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'(PS2_DATA_BITS - 1))
                        state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    par_ok_d = ^{shift_q, sdata};
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    if (sdata && par_ok_q) begin
                        if (shift_q == PS2_EXT) begin
                            ext_pend_d = 1'b1;
                        end else if (shift_q == PS2_BRK) begin
                            brk_pend_d = 1'b1;
                        end else begin
                            valid_d    = 1'b1;
                            scancode_d = shift_q;
                            is_ext_d   = ext_pend_q;
                            is_break_d = brk_pend_q;
                            ext_pend_d = 1'b0;
                            brk_pend_d = 1'b0;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A stalled frame is abandoned; fall resets tmo_q so this cannot
        // coincide with the stop-bit handling above.
        if (state_q != ST_IDLE && !fall && tmo_q == TMO_LAST) begin
            err_d    = 1'b1;
            state_d  = ST_IDLE;
            shift_d  = '0;
            bitcnt_d = '0;
        end

        if (err_d) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            par_ok_q   <= 1'b0;
            tmo_q      <= '0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            scancode_q <= '0;
            is_ext_q   <= 1'b0;
            is_break_q <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            par_ok_q   <= par_ok_d;
            tmo_q      <= tmo_d;
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
            scancode_q <= scancode_d;
            is_ext_q   <= is_ext_d;
            is_break_q <= is_break_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign evt.scancode = scancode_q;
    assign evt.is_ext   = is_ext_q;
    assign evt.is_break = is_break_q;
    assign evt.keycode  = {keycode_hi(is_break_q, is_ext_q), scancode_q};
    assign evt.valid    = valid_q;
    assign evt.err      = err_q;

endmodule
